// File: rtl/bit_column_sparse_encoder.sv
// Bit-column sparse encoder: walks a captured weight vector LSB to MSB, one column
// per beat, encoding each group's column as activation mux selects plus a skip-zero mode flag.
module bit_column_sparse_encoder #(
   parameter int DATA_WIDTH    = 8,
   parameter int VEC_LENGTH    = 32,
   parameter int GROUP_SIZE    = 8,
   parameter int SEL_PER_GROUP = GROUP_SIZE / 2,
   parameter int SEL_WIDTH     = $clog2(GROUP_SIZE + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          w_valid,
   output logic                          w_ready,
   input  logic signed [DATA_WIDTH-1:0]  w_in [VEC_LENGTH],
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SEL_WIDTH-1:0]          act_sel [VEC_LENGTH/2],
   output logic                          is_skip_zero [VEC_LENGTH/GROUP_SIZE],
   output logic [$clog2(DATA_WIDTH)-1:0] column_idx,
   output logic                          is_msb,
   output logic                          first_col,
   output logic                          last_col
);

   localparam int COL_W      = $clog2(DATA_WIDTH);
   localparam int NUM_GROUPS = VEC_LENGTH / GROUP_SIZE;

   typedef enum logic {IDLE, ENCODE} state_t;

   state_t                        state_q, state_d;
   logic [COL_W-1:0]              col_q, col_d;
   logic signed [DATA_WIDTH-1:0]  w_q [VEC_LENGTH];
   logic signed [DATA_WIDTH-1:0]  w_d [VEC_LENGTH];
   logic                          col_last;
   logic                          accept;

   assign col_last = (col_q == COL_W'(DATA_WIDTH - 1));
   assign accept   = w_valid && w_ready;

   // State register; the weight register needs no reset since a vector is only
   // ever observed after it has been accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
      end
   end

   always_ff @(posedge clk) begin
      w_q <= w_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      w_d     = w_q;
      if (accept) begin
         w_d = w_in;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ENCODE;
               col_d   = '0;
            end
         end
         ENCODE: begin
            if (out_ready) begin
               if (!col_last) begin
                  col_d = col_q + COL_W'(1);
               end else if (accept) begin
                  col_d = '0;
               end else begin
                  state_d = IDLE;
                  col_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            col_d   = '0;
         end
      endcase
   end

   // Output logic; every beat flag is forced to its idle value when no beat is valid.
   always_comb begin
      out_valid  = (state_q == ENCODE);
      w_ready    = (state_q == IDLE) || ((state_q == ENCODE) && col_last && out_ready);
      column_idx = out_valid ? col_q : '0;
      is_msb     = out_valid && col_last;
      first_col  = out_valid && (col_q == '0);
      last_col   = out_valid && col_last;
   end

   genvar gi, ki, si;
   generate
      for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
         logic [GROUP_SIZE-1:0] bits;
         logic [GROUP_SIZE-1:0] tgt;
         logic [SEL_WIDTH-1:0]  pop;
         logic [SEL_WIDTH-1:0]  cnt;
         logic [SEL_WIDTH-1:0]  sel [SEL_PER_GROUP];
         logic                  ones_mode;

         for (ki = 0; ki < GROUP_SIZE; ki++) begin : g_bit
            assign bits[ki] = w_q[gi*GROUP_SIZE + ki][col_q];
         end

         always_comb begin
            pop = '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
               pop = pop + SEL_WIDTH'(bits[k]);
            end
         end

         // A half-full column stays in ones mode; denser columns select the zeros instead.
         assign ones_mode = (pop <= SEL_WIDTH'(GROUP_SIZE / 2));
         assign tgt       = ones_mode ? bits : ~bits;

         always_comb begin
            cnt = '0;
            for (int s = 0; s < SEL_PER_GROUP; s++) begin
               sel[s] = '0;
            end
            for (int k = 0; k < GROUP_SIZE; k++) begin
               if (tgt[k]) begin
                  for (int s = 0; s < SEL_PER_GROUP; s++) begin
                     if (cnt == SEL_WIDTH'(s)) begin
                        sel[s] = SEL_WIDTH'(k + 1);
                     end
                  end
               end
               cnt = cnt + SEL_WIDTH'(tgt[k]);
            end
         end

         assign is_skip_zero[gi] = out_valid ? ones_mode : 1'b1;

         for (si = 0; si < SEL_PER_GROUP; si++) begin : g_slot
            assign act_sel[gi*SEL_PER_GROUP + si] = out_valid ? sel[si] : '0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_bit_column_sparse_encoder.sv
// Directed bench for bit_column_sparse_encoder: hand-computed column encodings,
// stall, back-to-back vectors and mid-vector reset.
module tb_bit_column_sparse_encoder;

   logic              clk;
   logic              reset;
   logic              w_valid;
   logic              w_ready;
   logic signed [7:0] w_in [32];
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        act_sel [16];
   logic              is_skip_zero [4];
   logic [2:0]        column_idx;
   logic              is_msb;
   logic              first_col;
   logic              last_col;

   int total = 0;
   int bad   = 0;

   bit_column_sparse_encoder dut (
      .clk          (clk),
      .reset        (reset),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_in         (w_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .act_sel      (act_sel),
      .is_skip_zero (is_skip_zero),
      .column_idx   (column_idx),
      .is_msb       (is_msb),
      .first_col    (first_col),
      .last_col     (last_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] sel_vec();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[4*i +: 4] = act_sel[i];
      return v;
   endfunction

   function automatic logic [3:0] skip_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = is_skip_zero[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input int col, input logic [3:0] skip,
                           input logic [63:0] sel);
      string t;
      t = $sformatf("%s_c%0d", tag, col);
      chk({t, "_valid"}, 64'(out_valid), 64'd1);
      chk({t, "_colidx"}, 64'(column_idx), 64'(col));
      chk({t, "_skip"}, 64'(skip_vec()), 64'(skip));
      chk({t, "_sel"}, sel_vec(), sel);
      chk({t, "_msb"}, 64'(is_msb), 64'(col == 7));
      chk({t, "_first"}, 64'(first_col), 64'(col == 0));
      chk({t, "_last"}, 64'(last_col), 64'(col == 7));
      $display("beat %s skip=%b sel=%h", t, skip_vec(), sel_vec());
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_wready"}, 64'(w_ready), 64'd1);
      chk({tag, "_skip"}, 64'(skip_vec()), 64'hF);
      chk({tag, "_sel"}, sel_vec(), 64'd0);
      chk({tag, "_colidx"}, 64'(column_idx), 64'd0);
      chk({tag, "_flags"}, 64'({is_msb, first_col, last_col}), 64'd0);
      $display("idle %s", tag);
   endtask

   task automatic clear_w();
      for (int i = 0; i < 32; i++) w_in[i] = 8'sh00;
   endtask

   initial begin
      reset     = 1'b1;
      w_valid   = 1'b0;
      out_ready = 1'b1;
      clear_w();
      repeat (2) @(negedge clk);
      chk_idle("rst0");
      reset = 1'b0;
      @(negedge clk);
      chk_idle("idle0");

      // All weights 0x01: column 0 is full (zeros mode, no selects), rest empty
      for (int i = 0; i < 32; i++) w_in[i] = 8'sh01;
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      chk_beat("ones", 0, 4'b0000, 64'd0);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         chk_beat("ones", c, 4'b1111, 64'd0);
      end
      chk("ones_wready_c7", 64'(w_ready), 64'd1);
      @(negedge clk);
      chk_idle("ones_end");

      // Group 0 idx0 and idx7 = 0x80: only the sign column has bits, slots {1,8,0,0}
      clear_w();
      w_in[0] = 8'sh80;
      w_in[7] = 8'sh80;
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk_beat("msb", c, 4'b1111, (c == 7) ? 64'h81 : 64'd0);
         @(negedge clk);
      end
      chk_idle("msb_end");

      // Column 3: group2 ones {1,2,5} -> slots {2,3,6,0}; group3 zero at 2 -> slot {3}
      clear_w();
      w_in[17] = 8'sh08;
      w_in[18] = 8'sh08;
      w_in[21] = 8'sh08;
      for (int i = 24; i < 32; i++) w_in[i] = (i == 26) ? 8'sh00 : 8'sh08;
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_beat("mix", c, 4'b1111, 64'd0);
         @(negedge clk);
      end
      chk_beat("mix", 3, 4'b0111, 64'h0003_0632_0000_0000);

      // Stall at column 3 while offering the next vector (must be ignored)
      out_ready = 1'b0;
      clear_w();
      for (int i = 8; i < 16; i++) w_in[i] = (i == 12) ? 8'sh00 : 8'sh01;
      w_valid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk_beat($sformatf("stall%0d", s), 3, 4'b0111, 64'h0003_0632_0000_0000);
         chk($sformatf("stall%0d_wready", s), 64'(w_ready), 64'd0);
      end
      out_ready = 1'b1;
      for (int c = 4; c < 8; c++) begin
         @(negedge clk);
         chk_beat("mix", c, 4'b1111, 64'd0);
      end
      chk("b2b_wready_c7", 64'(w_ready), 64'd1);

      // Back-to-back: next vector starts without a bubble; group1 zero at idx4 -> slot 5
      @(negedge clk);
      w_valid = 1'b0;
      chk_beat("b2b", 0, 4'b1101, 64'h0000_0000_0005_0000);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         chk_beat("b2b", c, 4'b1111, 64'd0);
      end
      @(negedge clk);
      chk_idle("b2b_end");

      // Mid-vector reset at column 5
      for (int i = 0; i < 32; i++) w_in[i] = 8'sh01;
      w_valid = 1'b1;
      @(negedge clk);
      w_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
      end
      chk_beat("prerst", 5, 4'b1111, 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle("midrst");
      reset = 1'b0;
      @(negedge clk);
      chk_idle("postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
